// File: rtl/seq_tail_lights.sv
// seq_tail_lights
//   Sequential tail-light controller with N_LAMPS lamps per side. An internal
//   step divider advances the animation once every TICK_DIV clock cycles.
//   A turn request fills the lamps on its side from the inside out, then
//   clears them, and repeats. A hazard request flashes both sides together.
//   BRAKE lights every side that is not animated, except in hazard mode.
//   Any change of the decoded request restarts the animation from phase 0.
//
// Parameters
//   N_LAMPS   lamps per side (>=1); bit 0 is the innermost lamp
//   TICK_DIV  Clk cycles per animation step (>=1)
//
// Ports
//   Clk     system clock, rising edge
//   Rst     synchronous active-high reset
//   LEFT    left turn request (level)
//   RIGHT   right turn request (level)
//   HAZ     hazard request (level, highest priority)
//   BRAKE   brake request (level)
//   LAMP_L  left lamps, active-high, registered
//   LAMP_R  right lamps, active-high, registered
module seq_tail_lights #(
  parameter int N_LAMPS  = 3,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               LEFT,
  input  logic               RIGHT,
  input  logic               HAZ,
  input  logic               BRAKE,
  output logic [N_LAMPS-1:0] LAMP_L,
  output logic [N_LAMPS-1:0] LAMP_R
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_W  = $clog2(N_LAMPS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(N_LAMPS);

  typedef enum logic [1:0] {
    IDLE,
    LEFT_SEQ,
    RIGHT_SEQ,
    HAZARD
  } mode_t;

  mode_t              mode,     mode_nxt, dec_mode;
  logic [CNT_W-1:0]   cnt,      cnt_nxt;
  logic [PH_W-1:0]    phase,    phase_nxt;
  logic [N_LAMPS-1:0] lamp_l_nxt, lamp_r_nxt;
  logic [N_LAMPS-1:0] seq_pat, brake_pat;
  logic               step;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    // Request decode; LEFT and RIGHT together fall through to IDLE.
    dec_mode = IDLE;
    if (HAZ)                dec_mode = HAZARD;
    else if (LEFT && !RIGHT) dec_mode = LEFT_SEQ;
    else if (RIGHT && !LEFT) dec_mode = RIGHT_SEQ;

    step      = (cnt == CNT_LAST);
    mode_nxt  = mode;
    cnt_nxt   = cnt;
    phase_nxt = phase;

    if (dec_mode != mode) begin
      // A mode change restarts the animation and swallows any coincident step.
      mode_nxt  = dec_mode;
      cnt_nxt   = '0;
      phase_nxt = '0;
    end else begin
      cnt_nxt = step ? '0 : cnt + CNT_W'(1);
      if (step) begin
        unique case (mode)
          LEFT_SEQ, RIGHT_SEQ: phase_nxt = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
          HAZARD:              phase_nxt = phase ^ PH_W'(1);
          default:             phase_nxt = '0;
        endcase
      end
    end

    // Fill pattern: the low phase_nxt lamps are lit, i.e. (1 << phase) - 1.
    seq_pat = '0;
    for (int i = 0; i < N_LAMPS; i++) begin
      seq_pat[i] = (PH_W'(i) < phase_nxt);
    end
    brake_pat = {N_LAMPS{BRAKE}};

    // Lamps follow the next-state mode/phase so they match the state after
    // the edge; only BRAKE is taken from the current inputs.
    lamp_l_nxt = brake_pat;
    lamp_r_nxt = brake_pat;
    unique case (mode_nxt)
      LEFT_SEQ:  lamp_l_nxt = seq_pat;
      RIGHT_SEQ: lamp_r_nxt = seq_pat;
      HAZARD: begin
        lamp_l_nxt = phase_nxt[0] ? '0 : '1;
        lamp_r_nxt = phase_nxt[0] ? '0 : '1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mode   <= IDLE;
      cnt    <= '0;
      phase  <= '0;
      LAMP_L <= '0;
      LAMP_R <= '0;
    end else begin
      mode   <= mode_nxt;
      cnt    <= cnt_nxt;
      phase  <= phase_nxt;
      LAMP_L <= lamp_l_nxt;
      LAMP_R <= lamp_r_nxt;
    end
  end

endmodule

// File: tb/tb_seq_tail_lights.sv
// Self-checking bench for seq_tail_lights. Two instances share the request
// inputs: one with N_LAMPS=3/TICK_DIV=4 and one with N_LAMPS=5/TICK_DIV=1.
// The reference model tracks only the active mode and the number of edges
// since that mode was entered; lamp patterns follow from integer arithmetic.
module tb_seq_tail_lights;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left = 1'b0, right = 1'b0, haz = 1'b0, brake = 1'b0;
  logic [2:0] lamp_l3, lamp_r3;
  logic [4:0] lamp_l5, lamp_r5;

  int checks = 0;
  int errors = 0;

  seq_tail_lights #(.N_LAMPS(3), .TICK_DIV(4)) dut3 (
    .Clk(clk), .Rst(rst), .LEFT(left), .RIGHT(right), .HAZ(haz), .BRAKE(brake),
    .LAMP_L(lamp_l3), .LAMP_R(lamp_r3)
  );

  seq_tail_lights #(.N_LAMPS(5), .TICK_DIV(1)) dut5 (
    .Clk(clk), .Rst(rst), .LEFT(left), .RIGHT(right), .HAZ(haz), .BRAKE(brake),
    .LAMP_L(lamp_l5), .LAMP_R(lamp_r5)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_LEFT, M_RIGHT, M_HAZ} tb_mode_t;

  tb_mode_t    m_mode [2];
  int          m_e    [2];
  logic [4:0]  e_l    [2];
  logic [4:0]  e_r    [2];
  logic [15:0] exp_v;
  int          cfg_n  [2] = '{3, 5};
  int          cfg_t  [2] = '{4, 1};

  function automatic tb_mode_t decode(input logic h, input logic l, input logic r);
    if (h)           return M_HAZ;
    if (l && !r)     return M_LEFT;
    if (r && !l)     return M_RIGHT;
    return M_IDLE;
  endfunction

  function automatic void model_lamps(input int n, input int t, input tb_mode_t m,
                                      input int e, input logic brk,
                                      output logic [4:0] l, output logic [4:0] r);
    int steps, all_on, seq, brk_v, haz_v;
    steps  = e / t;
    all_on = (1 << n) - 1;
    seq    = (1 << (steps % (n + 1))) - 1;
    brk_v  = brk ? all_on : 0;
    haz_v  = (steps % 2 == 0) ? all_on : 0;
    case (m)
      M_LEFT:  begin l = 5'(seq);   r = 5'(brk_v); end
      M_RIGHT: begin l = 5'(brk_v); r = 5'(seq);   end
      M_HAZ:   begin l = 5'(haz_v); r = 5'(haz_v); end
      default: begin l = 5'(brk_v); r = 5'(brk_v); end
    endcase
  endfunction

  // One clock edge: advance the model with the inputs the DUT samples, then
  // step 1 time unit past the edge so outputs are settled for comparison.
  task automatic tick();
    tb_mode_t d;
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        m_mode[c] = M_IDLE;
        m_e[c]    = 0;
        e_l[c]    = '0;
        e_r[c]    = '0;
      end else begin
        d = decode(haz, left, right);
        if (d != m_mode[c]) begin
          m_mode[c] = d;
          m_e[c]    = 0;
        end else begin
          m_e[c]++;
        end
        model_lamps(cfg_n[c], cfg_t[c], m_mode[c], m_e[c], brake, e_l[c], e_r[c]);
      end
    end
    exp_v = {e_l[0][2:0], e_r[0][2:0], e_l[1], e_r[1]};
    #1;
  endtask

  task automatic set_req(input logic h, input logic l, input logic r, input logic b);
    haz = h; left = l; right = r; brake = b;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_req(1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({lamp_l3, lamp_r3, lamp_l5, lamp_r5} !== 16'h0000) begin
        errors++;
        $display("FAIL reset cyc%0d: lamps=%b required=%b", i,
                 {lamp_l3, lamp_r3, lamp_l5, lamp_r5}, 16'h0000);
      end
    end
  endtask

  task automatic test_left_seq();
    logic [2:0] lc  [5] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
    logic [4:0] l5c [7] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111,
                            5'b01111, 5'b11111, 5'b00000};
    set_req(1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      tick();
      checks++;
      if ({lamp_l3, lamp_r3, lamp_l5, lamp_r5} !== exp_v) begin
        errors++;
        $display("FAIL left_seq model cyc%0d: lamps=%b expected=%b", i,
                 {lamp_l3, lamp_r3, lamp_l5, lamp_r5}, exp_v);
      end
      if (i == 0 || (i % 4 == 0)) begin
        checks++;
        if (lamp_l3 !== ((i == 0) ? 3'b000 : lc[i/4 - 1]) || lamp_r3 !== 3'b000) begin
          errors++;
          $display("FAIL left_seq n3 cyc%0d: L=%b R=%b required L=%b R=000", i,
                   lamp_l3, lamp_r3, (i == 0) ? 3'b000 : lc[i/4 - 1]);
        end
      end
      if (i < 7) begin
        checks++;
        if (lamp_l5 !== l5c[i]) begin
          errors++;
          $display("FAIL left_seq n5 cyc%0d: L=%b required %b", i, lamp_l5, l5c[i]);
        end
      end
    end
  endtask

  task automatic test_right_brake();
    set_req(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i <= 10; i++) begin
      tick();
      checks++;
      if ({lamp_l3, lamp_r3, lamp_l5, lamp_r5} !== exp_v || lamp_l3 !== 3'b111) begin
        errors++;
        $display("FAIL right_brake cyc%0d: lamps=%b expected=%b (L3 must be 111)", i,
                 {lamp_l3, lamp_r3, lamp_l5, lamp_r5}, exp_v);
      end
    end
    // Ten edges after entry: phase 2, counter mid-phase. Drop BRAKE.
    brake = 1'b0;
    tick();
    checks++;
    if (lamp_l3 !== 3'b000 || lamp_r3 !== 3'b011) begin
      errors++;
      $display("FAIL brake_release: L=%b R=%b required L=000 R=011", lamp_l3, lamp_r3);
    end
  endtask

  task automatic test_hazard();
    logic [2:0] want;
    set_req(1'b1, 1'b1, 1'b0, 1'b1);
    for (int j = 0; j <= 12; j++) begin
      tick();
      want = ((j / 4) % 2 == 0) ? 3'b111 : 3'b000;
      checks++;
      if (lamp_l3 !== want || lamp_r3 !== want ||
          {lamp_l3, lamp_r3, lamp_l5, lamp_r5} !== exp_v) begin
        errors++;
        $display("FAIL hazard cyc%0d: L=%b R=%b required %b (all lamps=%b model=%b)", j,
                 lamp_l3, lamp_r3, want, {lamp_l3, lamp_r3, lamp_l5, lamp_r5}, exp_v);
      end
    end
    haz = 1'b0;
    tick();
    checks++;
    if (lamp_l3 !== 3'b000 || lamp_r3 !== 3'b111) begin
      errors++;
      $display("FAIL hazard_exit: L=%b R=%b required L=000 R=111", lamp_l3, lamp_r3);
    end
    for (int j = 0; j < 4; j++) tick();
    checks++;
    if (lamp_l3 !== 3'b001) begin
      errors++;
      $display("FAIL hazard_exit_step: L=%b required 001", lamp_l3);
    end
  endtask

  task automatic test_both_requests();
    set_req(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({lamp_l3, lamp_r3, lamp_l5, lamp_r5} !== 16'h0000) begin
        errors++;
        $display("FAIL both_idle cyc%0d: lamps=%b required all 0", i,
                 {lamp_l3, lamp_r3, lamp_l5, lamp_r5});
      end
    end
    brake = 1'b1;
    tick();
    checks++;
    if ({lamp_l3, lamp_r3, lamp_l5, lamp_r5} !== 16'hFFFF) begin
      errors++;
      $display("FAIL both_brake: lamps=%b required all 1", {lamp_l3, lamp_r3, lamp_l5, lamp_r5});
    end
  endtask

  task automatic test_reset_mid();
    set_req(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (lamp_l3 !== 3'b011) begin
      errors++;
      $display("FAIL reset_mid_pre: L=%b required 011", lamp_l3);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({lamp_l3, lamp_r3, lamp_l5, lamp_r5} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid: lamps=%b required all 0", {lamp_l3, lamp_r3, lamp_l5, lamp_r5});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (lamp_l3 !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: L=%b required 000", lamp_l3);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (lamp_l3 !== 3'b001 || {lamp_l3, lamp_r3, lamp_l5, lamp_r5} !== exp_v) begin
      errors++;
      $display("FAIL reset_restart: L=%b required 001 (lamps=%b model=%b)", lamp_l3,
               {lamp_l3, lamp_r3, lamp_l5, lamp_r5}, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    // LEFT is still held at phase 1; a one-cycle gap must restart from 000.
    tick();
    tick();
    left = 1'b0;
    tick();
    left = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (lamp_l3 !== ((i == 4) ? 3'b001 : 3'b000) ||
          {lamp_l3, lamp_r3, lamp_l5, lamp_r5} !== exp_v) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: L=%b (lamps=%b model=%b)", i, lamp_l3,
                 {lamp_l3, lamp_r3, lamp_l5, lamp_r5}, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] req;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(4, 0) == 0) begin
        req = 4'($urandom);
        haz   = ($urandom_range(3, 0) == 0);
        left  = req[1];
        right = req[2];
        brake = req[3];
      end
      rst = ($urandom_range(99, 0) == 0);
      tick();
      checks++;
      if ({lamp_l3, lamp_r3, lamp_l5, lamp_r5} !== exp_v) begin
        errors++;
        $display("FAIL random cyc%0d: lamps=%b expected=%b", i,
                 {lamp_l3, lamp_r3, lamp_l5, lamp_r5}, exp_v);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_left_seq();
    test_right_brake();
    test_hazard();
    test_both_requests();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
